// File: rtl/onehot_grant_decoder.sv
// rtl/onehot_grant_decoder.sv - encoded index to held one-hot grant with ack/timeout release
// Optional macro ONEHOT_GRANT_B2B_EN: accept the next index in the ack-release cycle.
module onehot_grant_decoder #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = $clog2(WIDTH),
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_enc,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      grant,
  input  logic [WIDTH-1:0]      ack,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] cur_idx,
  output logic                  done,
  output logic                  timeout,
  output logic                  err
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam int TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TLAST = TLAST_I[TW-1:0];
  localparam logic [TW-1:0] TMAX  = '1;
  localparam logic [ADDR_WIDTH:0] WIDTH_L = WIDTH[ADDR_WIDTH:0];
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]    state;
  logic [TW-1:0] timer;
  logic          ack_hit;
  logic          in_range;
  logic          xfer;

  // grant is one-hot on cur_idx while held, so masking ack selects ack[cur_idx]
  assign ack_hit  = (state == GRANT) && ((ack & grant) != '0);
  assign in_range = ({1'b0, in_enc} < WIDTH_L);
  assign busy     = (state == GRANT);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (state == IDLE) begin
        in_ready = 1'b1;
      end else begin
`ifdef ONEHOT_GRANT_B2B_EN
        in_ready = ack_hit;
`else
        in_ready = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      cur_idx <= '0;
      timer   <= '0;
      done    <= 1'b0;
      timeout <= 1'b0;
      err     <= 1'b0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      err     <= 1'b0;
      if (state == GRANT) begin
        if (ack_hit || ((TIMEOUT != 0) && (timer == TLAST))) begin
          state   <= IDLE;
          grant   <= '0;
          cur_idx <= '0;
          timer   <= '0;
          done    <= ack_hit;
          timeout <= !ack_hit;
        end else if (timer != TMAX) begin
          timer <= timer + 1'b1;
        end
      end
      // a transfer in GRANT only happens in the ack-release cycle, so it overrides the release
      if (xfer) begin
        if (in_range) begin
          state   <= GRANT;
          grant   <= ONE << in_enc;
          cur_idx <= in_enc;
          timer   <= '0;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_onehot_grant_decoder.sv
// tb/tb_onehot_grant_decoder.sv - randomized check of two decoder configurations against a cycle model
module tb_onehot_grant_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst      [2];
  logic       in_valid [2];
  logic [2:0] in_enc   [2];
  logic [7:0] ack      [2];

  logic       rdy8, busy8, done8, tmo8, err8;
  logic [7:0] grant8;
  logic [2:0] cur8;
  logic       rdy6, busy6, done6, tmo6, err6;
  logic [5:0] grant6, ack6;
  logic [2:0] cur6;

  assign ack6 = ack[1][5:0];

  onehot_grant_decoder #(.WIDTH(8), .TIMEOUT(16)) u_dut8 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_enc(in_enc[0]), .in_ready(rdy8),
    .grant(grant8), .ack(ack[0]), .busy(busy8), .cur_idx(cur8), .done(done8),
    .timeout(tmo8), .err(err8)
  );

  onehot_grant_decoder #(.WIDTH(6), .TIMEOUT(4)) u_dut6 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_enc(in_enc[1]), .in_ready(rdy6),
    .grant(grant6), .ack(ack6), .busy(busy6), .cur_idx(cur6), .done(done6),
    .timeout(tmo6), .err(err6)
  );

  // idx = held line or -1 when idle; age = cycles the grant has been visible so far
  typedef struct {
    int idx;
    int age;
    bit done;
    bit tmo;
    bit err;
  } mstate_t;

  mstate_t ms [2];
  int wid [2] = '{8, 6};
  int tlim [2] = '{16, 4};
  int n_cmp = 0;
  int n_bad = 0;
  bit b2b;
  int cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit model_ready(mstate_t s, logic r, logic [7:0] a);
    if (r) return 1'b0;
    if (s.idx < 0) return 1'b1;
    return b2b && a[s.idx];
  endfunction

  function automatic mstate_t model_step(mstate_t s, int w, int tl, logic r, logic v,
                                         int enc, logic [7:0] a);
    mstate_t n;
    bit rdy;
    rdy = model_ready(s, r, a);
    n = s;
    n.done = 0; n.tmo = 0; n.err = 0;
    if (r) begin
      n.idx = -1;
      n.age = 0;
      return n;
    end
    if (s.idx >= 0) begin
      if (a[s.idx]) begin
        n.done = 1; n.idx = -1; n.age = 0;
      end else if (tl != 0 && s.age == tl) begin
        n.tmo = 1; n.idx = -1; n.age = 0;
      end else begin
        n.age = s.age + 1;
      end
    end
    if (rdy && v) begin
      if (enc < w) begin
        n.idx = enc; n.age = 1;
      end else begin
        n.err = 1;
      end
    end
    return n;
  endfunction

  task automatic check_outs(input int k, input logic [7:0] g, input logic b, input logic [2:0] c,
                            input logic d, input logic t, input logic e);
    mstate_t s;
    s = ms[k];
    check($sformatf("grant%0d", wid[k]), {24'd0, g}, (s.idx >= 0) ? (32'd1 << s.idx) : 32'd0);
    check($sformatf("busy%0d", wid[k]), {31'd0, b}, {31'd0, s.idx >= 0});
    check($sformatf("cur_idx%0d", wid[k]), {29'd0, c}, (s.idx >= 0) ? s.idx : 0);
    check($sformatf("done%0d", wid[k]), {31'd0, d}, {31'd0, s.done});
    check($sformatf("timeout%0d", wid[k]), {31'd0, t}, {31'd0, s.tmo});
    check($sformatf("err%0d", wid[k]), {31'd0, e}, {31'd0, s.err});
  endtask

  initial begin
    int den;
    logic [7:0] a;
`ifdef ONEHOT_GRANT_B2B_EN
    b2b = 1'b1;
`else
    b2b = 1'b0;
`endif
    cyc = 0;
    den = 20;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; in_valid[k] = 1'b0; in_enc[k] = '0; ack[k] = '0;
      ms[k] = '{idx: -1, age: 0, done: 0, tmo: 0, err: 0};
    end
    repeat (2) @(posedge clk);
    for (cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk);
      #1;
      check_outs(0, grant8, busy8, cur8, done8, tmo8, err8);
      check_outs(1, {2'b00, grant6}, busy6, cur6, done6, tmo6, err6);
      if (cyc % 300 == 0) begin
        case ($urandom_range(0, 2))
          0: den = 1000000;
          1: den = 20;
          default: den = 3;
        endcase
      end
      for (int k = 0; k < 2; k++) begin
        rst[k]      = ($urandom_range(0, 99) == 0);
        in_valid[k] = 1'($urandom_range(0, 1));
        in_enc[k]   = 3'($urandom_range(0, 7));
        a = 8'($urandom_range(0, 255));
        if (ms[k].idx >= 0) a[ms[k].idx] = ($urandom_range(0, den - 1) == 0);
        ack[k] = a;
      end
      #4;
      check("in_ready8", {31'd0, rdy8}, {31'd0, model_ready(ms[0], rst[0], ack[0])});
      check("in_ready6", {31'd0, rdy6}, {31'd0, model_ready(ms[1], rst[1], {2'b00, ack[1][5:0]})});
      for (int k = 0; k < 2; k++) begin
        a = (k == 0) ? ack[k] : {2'b00, ack[k][5:0]};
        ms[k] = model_step(ms[k], wid[k], tlim[k], rst[k], in_valid[k], int'(in_enc[k]), a);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
